vga_scan_ctrl: RTL and testbench

- Raster scan sequencer for the 640x480@60 display path.
- Divides clk_100mhz into a 25 MHz pixel tick and generates horizontal/vertical timing.
- Fetches a 4-bit tile category per pixel from the tile-map RAM (16x16-pixel tiles, 40x30 grid) and drives it to the category-to-RGB colour stage.
- Delays hsync/vsync so they line up with the colour stage's registered RGB outputs.

---
 rtl/vga_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_scan_ctrl
//
// Raster scan sequencer for the 640x480@60 display path. It divides the
// 100 MHz system clock into a 25 MHz pixel tick, runs the horizontal and
// vertical counters, fetches a 4-bit tile category per visible pixel from the
// tile-map RAM (16x16-pixel tiles, 40-tile rows) and hands it to the
// category-to-RGB colour stage. hsync/vsync are delayed so their edges line up
// with the colour stage's registered RGB outputs.
//
// Pipeline (each stage is one clk_100mhz cycle):
//   p0 : divider, x/y counters, frame_start          (updates on tick only)
//   p1 : map_rd / map_addr issued to the tile-map RAM
//   p2 : RAM access cycle (map_data valid during this cycle)
//   p3 : category / video_on registered
//   sync shift register output = p3 + 1 (colour stage RGB register)
//
// Ports:
//   clk_100mhz  in   1   system clock
//   rst_n       in   1   asynchronous active-low reset
//   enable      in   1   scan enable; low holds the raster idle at (0,0)
//   test_mode   in   1   (SCAN_TEST_PATTERN_EN only) checkerboard pattern
//   map_addr    out  11  tile-map read address
//   map_rd      out  1   tile-map read strobe (1 cycle per active pixel)
//   map_data    in   4   tile category, valid 1 cycle after map_rd
//   category    out  4   category to the colour stage, 0 = NONE
//   video_on    out  1   active-area flag aligned with category
//   hsync       out  1   active-low, aligned with colour stage RGB
//   vsync       out  1   active-low, aligned with colour stage RGB
//   frame_start out  1   1-cycle pulse when pixel (0,0) is issued
//   x           out  10  current pixel column (stage p0)
//   y           out  10  current pixel line (stage p0)
//
// Optional feature macro: SCAN_TEST_PATTERN_EN
//   When defined, a test_mode input is added. With test_mode=1 the category
//   becomes a NONE/TANK checkerboard derived from the tile coordinates and no
//   tile-map reads are issued. Sync timing is unaffected.
// -----------------------------------------------------------------------------
module vga_scan_ctrl #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned TILE_SHIFT = 4,
  parameter int unsigned MAP_COLS   = 40
) (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  input  logic        enable,
`ifdef SCAN_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic [10:0] map_addr,
  output logic        map_rd,
  input  logic [3:0]  map_data,
  output logic [3:0]  category,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [9:0]  x,
  output logic [9:0]  y
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_L  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_L  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] MAP_COLS_L = 11'(MAP_COLS);

  // Tile-map address: (row tile) * MAP_COLS + (column tile). The multiply is
  // unrolled into shifted adds over the set bits of the constant MAP_COLS
  // (40 = 32 + 8), so no multiplier is inferred.
  function automatic logic [10:0] tile_index(input logic [9:0] px,
                                             input logic [9:0] py);
    logic [9:0]  col;
    logic [9:0]  row;
    logic [10:0] acc;
    col = px >> TILE_SHIFT;
    row = py >> TILE_SHIFT;
    acc = 11'(col);
    for (int b = 0; b < 11; b++) begin
      if (MAP_COLS_L[b]) acc = acc + (11'(row) << b);
    end
    return acc;
  endfunction

  // Stage p0 state
  logic [DIV_W-1:0] div_p0;
  logic             first_p0;   // next tick issues (0,0) without advancing
  logic             vld_p0;     // 1-cycle pulse after each counter update
  logic             tick;
  logic [9:0]       x_nxt;
  logic [9:0]       y_nxt;
  logic             act_p0;
  logic             pat_p0;
  logic             rd_go_p0;
  logic             hs_raw_p0;
  logic             vs_raw_p0;

  // Stages p1/p2 side-band
  logic vld_p1, act_p1, pat_p1, chk_p1;
  logic vld_p2, act_p2, pat_p2, chk_p2;

  // Sync delay lines, bit 3 drives the output
  logic [3:0] hs_sr;
  logic [3:0] vs_sr;

`ifdef SCAN_TEST_PATTERN_EN
  assign pat_p0 = test_mode;
`else
  assign pat_p0 = 1'b0;
`endif

  assign tick      = enable && (div_p0 == DIV_LAST);
  assign act_p0    = (x < H_ACT_L) && (y < V_ACT_L);
  assign rd_go_p0  = vld_p0 && act_p0 && !pat_p0;
  assign hs_raw_p0 = !((x >= HS_BEG) && (x < HS_END));
  assign vs_raw_p0 = !((y >= VS_BEG) && (y < VS_END));

  // Position the counters move to on the next tick. Right after reset or
  // enable the raster already sits at (0,0); the first tick issues that
  // pixel rather than stepping past it.
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (first_p0) begin
      x_nxt = '0;
      y_nxt = '0;
    end else if (x == H_LAST) begin
      x_nxt = '0;
      y_nxt = (y == V_LAST) ? 10'd0 : y + 10'd1;
    end else begin
      x_nxt = x + 10'd1;
    end
  end

  // ---- stage p0: pixel divider and raster counters ----
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      div_p0      <= '0;
      x           <= '0;
      y           <= '0;
      first_p0    <= 1'b1;
      vld_p0      <= 1'b0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      div_p0      <= '0;
      x           <= '0;
      y           <= '0;
      first_p0    <= 1'b1;
      vld_p0      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vld_p0      <= tick;
      frame_start <= tick && (x_nxt == 10'd0) && (y_nxt == 10'd0);
      if (tick) begin
        div_p0   <= '0;
        x        <= x_nxt;
        y        <= y_nxt;
        first_p0 <= 1'b0;
      end else begin
        div_p0 <= div_p0 + 1'b1;
      end
    end
  end

  // ---- stage p1: tile-map read request ----
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      map_rd   <= 1'b0;
      map_addr <= '0;
      vld_p1   <= 1'b0;
      act_p1   <= 1'b0;
      pat_p1   <= 1'b0;
      chk_p1   <= 1'b0;
    end else if (!enable) begin
      map_rd   <= 1'b0;
      vld_p1   <= 1'b0;
      act_p1   <= 1'b0;
      pat_p1   <= 1'b0;
      chk_p1   <= 1'b0;
    end else begin
      map_rd <= rd_go_p0;
      vld_p1 <= vld_p0;
      act_p1 <= act_p0;
      pat_p1 <= pat_p0;
      // Checkerboard bit: LSB of the column tile XOR LSB of the row tile.
      chk_p1 <= x[TILE_SHIFT] ^ y[TILE_SHIFT];
      // Address holds through blanking so the RAM bus stays quiet.
      if (rd_go_p0) map_addr <= tile_index(x, y);
    end
  end

  // ---- stage p2: RAM access cycle ----
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      act_p2 <= 1'b0;
      pat_p2 <= 1'b0;
      chk_p2 <= 1'b0;
    end else if (!enable) begin
      vld_p2 <= 1'b0;
      act_p2 <= 1'b0;
      pat_p2 <= 1'b0;
      chk_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      act_p2 <= act_p1;
      pat_p2 <= pat_p1;
      chk_p2 <= chk_p1;
    end
  end

  // ---- stage p3: category register ----
  // Only the cycle carrying a new pixel loads; the value then holds for the
  // rest of that pixel's CLK_DIV cycles.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      category <= '0;
      video_on <= 1'b0;
    end else if (!enable) begin
      category <= '0;
      video_on <= 1'b0;
    end else if (vld_p2) begin
      video_on <= act_p2;
      if (!act_p2)
        category <= 4'd0;
      else if (pat_p2)
        category <= {2'b00, chk_p2, 1'b0};
      else
        category <= map_data;
    end
  end

  // ---- sync delay: p0 raw level -> p4, matching the colour stage RGB ----
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      hs_sr <= '1;
      vs_sr <= '1;
    end else if (!enable) begin
      hs_sr <= '1;
      vs_sr <= '1;
    end else begin
      hs_sr <= {hs_sr[2:0], hs_raw_p0};
      vs_sr <= {vs_sr[2:0], vs_raw_p0};
    end
  end

  assign hsync = hs_sr[3];
  assign vsync = vs_sr[3];

  // A read strobe never lasts more than one cycle when a pixel spans
  // several clocks.
  generate
    if (CLK_DIV > 1) begin : g_rd_pulse
      a_rd_pulse: assert property (@(posedge clk_100mhz) disable iff (!rst_n)
                                   map_rd |=> !map_rd);
    end
  endgenerate

endmodule

// File: tb/tb_vga_scan_ctrl.sv
`timescale 1ns/1ps
module tb_vga_scan_ctrl;

  // Reduced raster so a complete frame fits in a short run.
  localparam int H_ACT = 64;
  localparam int H_FPW = 8;
  localparam int H_SYW = 12;
  localparam int H_BPW = 12;
  localparam int V_ACT = 112;
  localparam int V_FPW = 4;
  localparam int V_SYW = 2;
  localparam int V_BPW = 2;
  localparam int DIV   = 4;
  localparam int H_TOT = H_ACT + H_FPW + H_SYW + H_BPW;   // 96
  localparam int V_TOT = V_ACT + V_FPW + V_SYW + V_BPW;   // 120

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  map_data;
  logic [10:0] map_addr;
  logic        map_rd;
  logic [3:0]  category;
  logic        video_on;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  logic [9:0]  x;
  logic [9:0]  y;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_scan_ctrl #(
    .H_ACTIVE(H_ACT), .H_FP(H_FPW), .H_SYNC(H_SYW), .H_BP(H_BPW),
    .V_ACTIVE(V_ACT), .V_FP(V_FPW), .V_SYNC(V_SYW), .V_BP(V_BPW),
    .CLK_DIV(DIV), .TILE_SHIFT(4), .MAP_COLS(40)
  ) dut (
    .clk_100mhz (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .map_addr   (map_addr),
    .map_rd     (map_rd),
    .map_data   (map_data),
    .category   (category),
    .video_on   (video_on),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_start(frame_start),
    .x          (x),
    .y          (y)
  );

  typedef struct {
    int         px;
    int         py;
    logic [3:0] data;
    logic       rd;
    int         addr;
    logic [3:0] cat;
    logic       von;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic wait_xy(input int wx, input int wy, input int budget,
                         output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(x) == wx && int'(y) == wy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // which: 0 = hsync, 1 = vsync, 2 = frame_start
  task automatic wait_lvl(input int which, input logic lvl, input int budget,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (which)
        0: ok = (hsync == lvl);
        1: ok = (vsync == lvl);
        default: ok = (frame_start == lvl);
      endcase
      if (ok) break;
    end
  endtask

  // Counts cycles from now until frame_start shows up.
  task automatic count_to_fs(input string name, input int exp);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (frame_start) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) tmo(name);
    else chk(name, n, exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int t_fs1, t_x, t_f1, t_r, t_f2, t_v;

    //            px  py  data   rd    addr cat    von
    vecs[0] = '{37,   0, 4'd1, 1'b1,   2, 4'd1, 1'b1};
    vecs[1] = '{63,   0, 4'd7, 1'b1,   3, 4'd7, 1'b1};  // last active column
    vecs[2] = '{65,   0, 4'hF, 1'b0,   3, 4'd0, 1'b0};  // front porch
    vecs[3] = '{90,   0, 4'hF, 1'b0,   3, 4'd0, 1'b0};  // back porch
    vecs[4] = '{17,   1, 4'd2, 1'b1,   1, 4'd2, 1'b1};
    vecs[5] = '{37, 100, 4'd1, 1'b1, 242, 4'd1, 1'b1};  // 6*40+2
    vecs[6] = '{63, 111, 4'd9, 1'b1, 243, 4'd9, 1'b1};  // last active line
    vecs[7] = '{10, 112, 4'hF, 1'b0, 243, 4'd0, 1'b0};  // vertical blank

    rst_n    = 1'b0;
    enable   = 1'b0;
    map_data = 4'd0;
    repeat (3) @(negedge clk);

    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_map_rd", int'(map_rd), 0);
    chk("rst_map_addr", int'(map_addr), 0);
    chk("rst_category", int'(category), 0);
    chk("rst_video_on", int'(video_on), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_frame_start", int'(frame_start), 0);

    // First tick lands CLK_DIV cycles after release and issues (0,0).
    enable = 1'b1;
    rst_n  = 1'b1;
    count_to_fs("first_tick_cycles", DIV);
    t_fs1 = cyc;
    chk("first_x", int'(x), 0);
    chk("first_y", int'(y), 0);
    @(negedge clk);
    chk("frame_start_pulse", int'(frame_start), 0);
    chk("first_map_rd", int'(map_rd), 1);
    chk("first_map_addr", int'(map_addr), 0);

    for (int i = 0; i < 8; i++) begin
      wait_xy(vecs[i].px, vecs[i].py, 60000, ok);
      if (!ok) begin
        tmo($sformatf("vec%0d_wait", i));
        continue;
      end
      @(negedge clk);
      chk($sformatf("vec%0d_map_rd", i), int'(map_rd), int'(vecs[i].rd));
      chk($sformatf("vec%0d_map_addr", i), int'(map_addr), vecs[i].addr);
      @(negedge clk);
      chk($sformatf("vec%0d_rd_one_cycle", i), int'(map_rd), 0);
      chk($sformatf("vec%0d_cat_not_early", i), int'(category), 0);
      map_data = vecs[i].data;
      @(negedge clk);
      chk($sformatf("vec%0d_category", i), int'(category), int'(vecs[i].cat));
      chk($sformatf("vec%0d_video_on", i), int'(video_on), int'(vecs[i].von));
      map_data = 4'd0;
    end

    // Line timing
    wait_xy(H_ACT + H_FPW, 113, 5000, ok);
    if (!ok) tmo("hs_x_wait");
    t_x = cyc;
    wait_lvl(0, 1'b0, 1000, ok);
    if (!ok) tmo("hs_fall_wait");
    else chk("hs_fall_delay", cyc - t_x, 4);
    t_f1 = cyc;
    wait_lvl(0, 1'b1, 1000, ok);
    if (!ok) tmo("hs_rise_wait");
    else chk("hs_low_cycles", cyc - t_f1, H_SYW * DIV);
    wait_lvl(0, 1'b0, 1000, ok);
    t_r = cyc;
    if (!ok) tmo("hs_refall_wait");
    else chk("hs_period", t_r - t_f1, H_TOT * DIV);

    // Frame timing
    wait_lvl(1, 1'b0, 5000, ok);
    t_v = cyc;
    if (!ok) tmo("vs_fall_wait");
    else chk("vs_fall_line", int'(y), V_ACT + V_FPW);
    wait_lvl(1, 1'b1, 2000, ok);
    if (!ok) tmo("vs_rise_wait");
    else chk("vs_low_cycles", cyc - t_v, V_SYW * H_TOT * DIV);
    wait_lvl(2, 1'b1, 50000, ok);
    t_f2 = cyc;
    if (!ok) tmo("frame_wait");
    else begin
      chk("frame_period", t_f2 - t_fs1, V_TOT * H_TOT * DIV);
      chk("frame_x", int'(x), 0);
      chk("frame_y", int'(y), 0);
    end

    // enable dropped in the middle of an active line
    map_data = 4'd6;
    wait_xy(30, 2, 2000, ok);
    if (!ok) tmo("drop1_wait");
    chk("drop1_pre_category", int'(category), 6);
    chk("drop1_pre_video_on", int'(video_on), 1);
    enable = 1'b0;
    @(negedge clk);
    chk("drop1_category", int'(category), 0);
    chk("drop1_video_on", int'(video_on), 0);
    chk("drop1_map_rd", int'(map_rd), 0);
    chk("drop1_x", int'(x), 0);
    chk("drop1_y", int'(y), 0);
    chk("drop1_hsync", int'(hsync), 1);
    chk("drop1_vsync", int'(vsync), 1);
    map_data = 4'd0;
    repeat (9) @(negedge clk);
    enable = 1'b1;
    count_to_fs("restart_tick_cycles", DIV);
    chk("restart_x", int'(x), 0);
    chk("restart_y", int'(y), 0);

    // enable dropped while hsync is low
    wait_xy(78, 0, 2000, ok);
    if (!ok) tmo("drop2_wait");
    chk("drop2_pre_hsync", int'(hsync), 0);
    enable = 1'b0;
    @(negedge clk);
    chk("drop2_hsync", int'(hsync), 1);
    enable = 1'b1;

    // Asynchronous reset mid-line
    wait_lvl(0, 1'b0, 1000, ok);
    if (!ok) tmo("reset_hs_wait");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hsync", int'(hsync), 1);
    chk("async_rst_x", int'(x), 0);
    chk("async_rst_map_addr", int'(map_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_to_fs("post_reset_tick_cycles", DIV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
